// File: rtl/scan_index_gen_pkg.sv
// Types and defaults shared by the scan sequencer and its slot divider.
`include "scan_defs.vh"

package scan_index_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = `SCAN_IDLE,
      ST_BLANK = `SCAN_BLANK,
      ST_SHOW  = `SCAN_SHOW
   } scan_state_t;

   localparam int DIVIDE_DEF       = `SCAN_DIVIDE_DEFAULT;
   localparam int BLANK_CYCLES_DEF = `SCAN_BLANK_CYCLES_DEFAULT;

   function automatic int cnt_width(input int divide);
      return (divide < 2) ? 1 : $clog2(divide);
   endfunction

endpackage

// File: rtl/scan_defs.vh
// Shared scan sequencer constants: state encodings and parameter defaults.
`ifndef SCAN_DEFS_VH
`define SCAN_DEFS_VH

`define SCAN_IDLE                 2'd0
`define SCAN_BLANK                2'd1
`define SCAN_SHOW                 2'd2

`define SCAN_DIVIDE_DEFAULT       1000
`define SCAN_BLANK_CYCLES_DEFAULT 8

`endif

// File: rtl/scan_index_gen_tick_div.sv
// Slot divider: counts 0..DIVIDE-1 and flags the last count as the slot tick.
// Count is registered, tick is decoded from it; clr forces the count to 0.
module scan_tick_div
   import scan_index_gen_pkg::*;
#(
   parameter int DIVIDE = DIVIDE_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   output logic [cnt_width(DIVIDE)-1:0]   cnt,
   output logic                           tick
);

   localparam int            CW       = cnt_width(DIVIDE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDE - 1);

   assign tick = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/scan_index_gen.sv
// Scan slot sequencer: sel advances every DIVIDE clocks through 0..last, with blank/wrap strobes.
// All outputs registered; SCAN_INDEX_GEN_BLANK_EN adds the BLANK_CYCLES blanking phase per slot.
module scan_index_gen
   import scan_index_gen_pkg::*;
#(
   parameter int DIVIDE       = DIVIDE_DEF,
   parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] last,
   output logic [1:0] sel,
   output logic       blank,
   output logic       wrap
);

   localparam int CW = cnt_width(DIVIDE);

   scan_state_t   state;
   scan_state_t   next_state;
   logic [CW-1:0] cnt;
   logic          tick;
   logic          clr;
   logic          adv;
   logic          at_last;

   // Counter sits at 0 while idle so each enable starts a fresh, full slot.
   assign clr     = (state == ST_IDLE) || !en;
   assign at_last = (sel >= last);

   scan_tick_div #(
      .DIVIDE (DIVIDE)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .cnt   (cnt),
      .tick  (tick)
   );

`ifndef SCAN_INDEX_GEN_BLANK_EN
   localparam int unused_blank_cycles = BLANK_CYCLES;
   logic          unused_cnt;
   assign unused_cnt = ^cnt;
`endif

   always_comb begin
      next_state = state;
      adv        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
`ifdef SCAN_INDEX_GEN_BLANK_EN
               next_state = ST_BLANK;
`else
               next_state = ST_SHOW;
`endif
            end
         end
`ifdef SCAN_INDEX_GEN_BLANK_EN
         ST_BLANK: begin
            if (!en) begin
               next_state = ST_IDLE;
            end else if (cnt == CW'(BLANK_CYCLES - 1)) begin
               next_state = ST_SHOW;
            end
         end
`endif
         ST_SHOW: begin
            // A disable on the tick cycle wins: no advance, no wrap.
            if (!en) begin
               next_state = ST_IDLE;
            end else if (tick) begin
               adv = 1'b1;
`ifdef SCAN_INDEX_GEN_BLANK_EN
               next_state = ST_BLANK;
`else
               next_state = ST_SHOW;
`endif
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sel   <= 2'd0;
         blank <= 1'b1;
         wrap  <= 1'b0;
      end else begin
         state <= next_state;
`ifdef SCAN_INDEX_GEN_BLANK_EN
         blank <= (next_state != ST_SHOW);
`else
         blank <= (next_state == ST_IDLE);
`endif
         wrap  <= adv && at_last;
         if (adv) begin
            sel <= at_last ? 2'd0 : sel + 2'd1;
         end
      end
   end

endmodule

// File: doc/scan_index_gen.md
# scan_index_gen

Time-multiplexed scan sequencer for 4-digit displays and keypad rows. It generates the 2-bit slot index that drives `decoder2to4`, advancing once every `DIVIDE` clocks and cycling through slots 0..`last`. It also produces a blanking strobe that suppresses ghosting while the decoded one-hot enables change, and a wrap pulse marking the start of each frame.

## Interface
Parameters:
- `DIVIDE`, default 1000: clocks per slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 8: clocks of blanking at the start of each slot; legal range 1..`DIVIDE`-1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  scan enable.
- `last`  in  2  highest slot index scanned (0..3); sampled only at slot ticks.
- `sel`  out  2  slot index; feeds `decoder2to4` input `i`.
- `blank`  out  1  1 = downstream must gate off all decoded enables.
- `wrap`  out  1  one-clock pulse, high in the first cycle `sel` holds 0 after a wrap.

All outputs are registered.

## Operation
- FSM states: IDLE, BLANK, SHOW. Slot counter `cnt` runs 0..`DIVIDE`-1.
- Reset (`rst_n`=0 at an edge) clears everything, overriding all other inputs, including mid-slot. Reset values: state IDLE, `cnt`=0, `sel`=0, `blank`=1, `wrap`=0.
- IDLE:
  - `cnt` is held at 0 and `sel` is held at its current value.
  - On `en`=1, go to BLANK.
- BLANK:
  - `cnt` increments each cycle.
  - When `cnt`==`BLANK_CYCLES`-1, go to SHOW.
- SHOW:
  - `cnt` increments each cycle.
  - At `cnt`==`DIVIDE`-1 (the tick): `cnt` goes to 0 and state goes to BLANK.
  - At the tick, `sel` goes to 0 if `sel` ≥ `last`; otherwise `sel` goes to `sel`+1.
  - `wrap` goes to 1 in the next cycle exactly when the tick sent `sel` to 0.
- `en`=0 in BLANK or SHOW: next state is IDLE and `cnt` goes to 0. `sel` is kept, so the scan resumes from the same slot.
- `blank` = (next state ≠ SHOW), registered.
- `last` lowered below the current `sel`: the next tick wraps to 0 and pulses `wrap`. There is no early abort.
- `last`=0: `sel` stays 0 and `wrap` pulses every slot.
- Simultaneous tick and `en`=0: `en` wins. State goes to IDLE, `sel` does not advance, and `wrap` stays 0.

## Timing
- Slot period is exactly `DIVIDE` clocks.
  - With blanking: `blank`=1 for `BLANK_CYCLES` clocks, then `blank`=0 for `DIVIDE`-`BLANK_CYCLES` clocks.
  - `sel` changes on the same edge at which `blank` rises.
- Enable latency: `en` high sampled at edge k → `blank` stays 1 from edge k for `BLANK_CYCLES` clocks.
- Disable latency: `en` low sampled at edge k → `blank`=1 from edge k.
- `wrap` is high for exactly one clock, coincident with the first cycle of the slot-0 blank.

## Configuration
- Macro: `SCAN_INDEX_GEN_BLANK_EN`.
- Defined:
  - Behaviour is as above.
- Undefined:
  - The BLANK state is not compiled. IDLE goes directly to SHOW, and a tick keeps the state in SHOW.
  - `blank` = (next state == IDLE).
  - `BLANK_CYCLES` is ignored.
  - Slot period and `wrap` behaviour are unchanged.

## Structure
- Shared include header `scan_defs.vh`:
  - state encodings `SCAN_IDLE`=2'd0, `SCAN_BLANK`=2'd1, `SCAN_SHOW`=2'd2.
  - default `DIVIDE` and `BLANK_CYCLES` values.
  - include guard.
- One sub-module, `scan_tick_div`:
  - parameterised `DIVIDE` counter with a clear input.
  - outputs `cnt` and a `tick` flag.
  - the counter width is derived from `DIVIDE`.
- The top level holds the FSM, the `sel`/`wrap` registers and the `last` comparison.

## Test plan
- Parameters `DIVIDE`=4, `BLANK_CYCLES`=1 unless stated.
1. Reset, `en`=1, `last`=3:
   - `sel` sequence 0,1,2,3,0 with each value held 4 clocks.
   - `blank`=1 in the first clock of every slot.
   - `wrap` high only on the return to 0.
2. `last`=1:
   - `sel` alternates 0,1.
   - `wrap` every 8 clocks.
   - Set `last`=0 while `sel`=1: the next tick gives `sel`=0 with `wrap`, then `sel` stays 0.
3. Drop `en` for 3 clocks at `sel`=2, mid-SHOW:
   - `blank`=1 immediately.
   - On `en` re-assert, `sel`=2 resumes with a full 4-clock slot.
4. Assert `rst_n`=0 for one clock mid-slot at `sel`=3:
   - Next cycle: `sel`=0, `blank`=1, `wrap`=0, state IDLE.
   - Drop `en` on the tick cycle: no advance and no `wrap`.
5. Build without `SCAN_INDEX_GEN_BLANK_EN`, `DIVIDE`=2:
   - `blank`=0 continuously while `en`=1.
   - `sel` advances every 2 clocks.
6. `DIVIDE`=1000, `BLANK_CYCLES`=8:
   - Measure exactly 8 blank clocks and 992 show clocks per slot across 2 full frames.
